centroid_tracker: RTL and testbench
===================================

CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameter NCH, default 2: number of independent colour channels tracked.
REQ-002 Parameter H_W, default 11: hcount width.
REQ-003 Parameter V_W, default 10: vcount width.
REQ-004 Parameter H_ACTIVE, default 1024: active pixels per line.
REQ-005 Parameter V_ACTIVE, default 768: active lines per frame.
REQ-006 Parameter SUM_W, default 32: accumulator and divider width.
REQ-007 Parameter CNT_W, default 20: per-channel pixel-count width.
REQ-008 Parameter MIN_COUNT, default 16 (legal range >= 1): minimum hits for a valid centroid.
REQ-009 Port clk, input, 1: single clock for all logic.
REQ-010 Port reset, input, 1: synchronous, active-high reset.
REQ-011 Port hcount, input, H_W: current pixel column.
REQ-012 Port vcount, input, V_W: current pixel line.
REQ-013 Port match, input, NCH: bit c high = current pixel belongs to channel c.
REQ-014 Port cx, output, NCH*H_W: channel c centroid column in bits [c*H_W +: H_W].
REQ-015 Port cy, output, NCH*V_W: channel c centroid line in bits [c*V_W +: V_W].
REQ-016 Port valid, output, NCH: bit c high = channel c had >= MIN_COUNT hits in the last processed frame.
REQ-017 Port busy, output, 1: high while the divider sequence runs.
REQ-018 Port done, output, 1: one-cycle pulse when all channels of a frame are processed.
REQ-019 Port overrun, output, 1: one-cycle pulse when a frame snapshot is dropped.

Function
REQ-020 Frame start = (hcount==0 && vcount==0); on that cycle, all accumulators clear and the pixel is not accumulated.
REQ-021 Active pixel = hcount<H_ACTIVE && vcount<V_ACTIVE && not frame start; per channel c with match[c]: sum_x[c]+=hcount, sum_y[c]+=vcount, count[c]+=1; multiple channels may accumulate the same pixel.
REQ-022 Frame end = (hcount==H_ACTIVE-1 && vcount==V_ACTIVE-1); that pixel accumulates, then on the next cycle all sums/counts copy into snapshot registers and the FSM leaves IDLE.
REQ-023 If frame end occurs while busy, the snapshot is not taken, the running sequence continues, and overrun pulses for 1 cycle.
REQ-024 FSM states: IDLE, CHECK, DIV_X, DIV_Y, STORE, DONE; channel index ch starts at 0.
REQ-025 CHECK (1 cycle): if snap_count[ch] >= MIN_COUNT go to DIV_X, else go to STORE with skip flag set.
REQ-026 DIV_X: shared restoring divider, 1 quotient bit per cycle, exactly SUM_W cycles, computes snap_sum_x[ch]/snap_count[ch] (unsigned, floor); then DIV_Y computes snap_sum_y[ch] the same way.
REQ-027 STORE (1 cycle): if not skipped, cx[ch] <= quotient_x[H_W-1:0], cy[ch] <= quotient_y[V_W-1:0], valid[ch] <= 1; if skipped, cx/cy hold and valid[ch] <= 0; then ch+1 -> CHECK, or DONE after ch==NCH-1.
REQ-028 DONE (1 cycle): done=1, ch <= 0, then IDLE.
REQ-029 Latency from the snapshot cycle to the done pulse = sum over channels of (2*SUM_W+2 if valid else 2) + 1 cycles; for defaults with both channels valid, 133 cycles.
REQ-030 busy is high in every state except IDLE.
REQ-031 Accumulation continues during the division of the previous frame; snapshot registers are never modified while busy.
REQ-032 Accumulators are not range-checked; the defaults are sized for no overflow at 1024x768.

Reset
REQ-033 While reset is high at a clock edge: accumulators, snapshots, cx, cy, valid, done and overrun are 0, busy is 0, the FSM is IDLE, and ch is 0.
REQ-034 Reset asserted mid-division aborts the sequence; no partial cx/cy update is ever visible.

Verification
REQ-035 MIN_COUNT=1, one ch0 hit at (100,50) -> after frame end: cx0=100, cy0=50, valid=2'b01, done 69 cycles after the snapshot (66+2+1).
REQ-036 ch1 10x10 block at h 200..209, v 300..309 -> count 100, cx1=204 (floor of 204.5), cy1=304, valid[1]=1.
REQ-037 ch0 with 5 hits (MIN_COUNT=16) after a valid frame with cx0=300 -> valid[0]=0, cx0 stays 300, ch0 takes 2 cycles.
REQ-038 Reset pulsed during DIV_Y of ch0 -> next cycle: busy=0, cx=cy=valid=0, and no done pulse.
REQ-039 A second frame end while busy (shortened frame timing) -> overrun pulses once, the first frame's results complete unchanged, and done pulses once.
REQ-040 Pixels matching both channels -> identical cx/cy on both channels.

Source files
------------

// File: rtl/centroid_tracker.sv
// Per-channel colour centroid tracker: accumulates matching pixel coordinates
// over a frame, then divides sums by hit counts with one shared serial divider.
`timescale 1ns/1ps

module centroid_tracker #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned H_W       = 11,
    parameter int unsigned V_W       = 10,
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned SUM_W     = 32,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [H_W-1:0]       hcount,
    input  logic [V_W-1:0]       vcount,
    input  logic [NCH-1:0]       match,
    output logic [NCH*H_W-1:0]   cx,
    output logic [NCH*V_W-1:0]   cy,
    output logic [NCH-1:0]       valid,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BIT_W = $clog2(SUM_W);
    localparam int unsigned REM_W = SUM_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_X,
        DIV_Y,
        STORE,
        DONE
    } state_t;

    logic [SUM_W-1:0]   sum_x_q   [NCH];
    logic [SUM_W-1:0]   sum_y_q   [NCH];
    logic [CNT_W-1:0]   cnt_q     [NCH];
    logic [SUM_W-1:0]   snap_x_q  [NCH];
    logic [SUM_W-1:0]   snap_y_q  [NCH];
    logic [CNT_W-1:0]   snap_cnt_q[NCH];

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic               skip_q;
    logic [BIT_W-1:0]   bit_q;
    logic [REM_W-1:0]   rem_q;
    logic [SUM_W-1:0]   quo_q;
    logic [SUM_W-1:0]   qx_q;
    logic               frame_end_q;
    logic [NCH*H_W-1:0] cx_q;
    logic [NCH*V_W-1:0] cy_q;
    logic [NCH-1:0]     valid_q;
    logic               busy_q;
    logic               done_q;
    logic               overrun_q;

    logic               frame_start_c;
    logic               active_c;
    logic               frame_end_c;
    logic [REM_W-1:0]   rem_shift_c;
    logic [REM_W-1:0]   divisor_c;
    logic               ge_c;
    logic [REM_W-1:0]   rem_d;
    logic [SUM_W-1:0]   quo_d;

    assign frame_start_c = (hcount == '0) && (vcount == '0);
    assign active_c      = (hcount < H_W'(H_ACTIVE)) && (vcount < V_W'(V_ACTIVE)) && !frame_start_c;
    assign frame_end_c   = (hcount == H_W'(H_ACTIVE - 1)) && (vcount == V_W'(V_ACTIVE - 1));

    // One restoring-division step: quo_q shifts the dividend out MSB-first and the quotient in.
    always_comb begin
        rem_shift_c = {rem_q[SUM_W-1:0], quo_q[SUM_W-1]};
        divisor_c   = REM_W'(snap_cnt_q[ch_q]);
        ge_c        = (rem_shift_c >= divisor_c);
        rem_d       = ge_c ? (rem_shift_c - divisor_c) : rem_shift_c;
        quo_d       = {quo_q[SUM_W-2:0], ge_c};
    end

    // Running per-frame accumulators; keep counting while the previous frame divides.
    always_ff @(posedge clk) begin
        if (reset || frame_start_c) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                sum_x_q[c] <= '0;
                sum_y_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
        end else if (active_c) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (match[c]) begin
                    sum_x_q[c] <= sum_x_q[c] + SUM_W'(hcount);
                    sum_y_q[c] <= sum_y_q[c] + SUM_W'(vcount);
                    cnt_q[c]   <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= frame_end_c;
        end
    end

    // Snapshot / divide / store sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                snap_x_q[c]   <= '0;
                snap_y_q[c]   <= '0;
                snap_cnt_q[c] <= '0;
            end
            state_q   <= IDLE;
            ch_q      <= '0;
            skip_q    <= 1'b0;
            bit_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            qx_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            valid_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= frame_end_q && busy_q;
            case (state_q)
                IDLE: begin
                    if (frame_end_q) begin
                        for (int unsigned c = 0; c < NCH; c++) begin
                            snap_x_q[c]   <= sum_x_q[c];
                            snap_y_q[c]   <= sum_y_q[c];
                            snap_cnt_q[c] <= cnt_q[c];
                        end
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    rem_q <= '0;
                    quo_q <= snap_x_q[ch_q];
                    bit_q <= '0;
                    if (snap_cnt_q[ch_q] >= CNT_W'(MIN_COUNT)) begin
                        skip_q  <= 1'b0;
                        state_q <= DIV_X;
                    end else begin
                        skip_q  <= 1'b1;
                        state_q <= STORE;
                    end
                end
                DIV_X: begin
                    if (bit_q == BIT_W'(SUM_W - 1)) begin
                        qx_q    <= quo_d;
                        rem_q   <= '0;
                        quo_q   <= snap_y_q[ch_q];
                        bit_q   <= '0;
                        state_q <= DIV_Y;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        bit_q <= bit_q + BIT_W'(1);
                    end
                end
                DIV_Y: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    bit_q <= bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(SUM_W - 1)) begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    if (skip_q) begin
                        valid_q[ch_q] <= 1'b0;
                    end else begin
                        cx_q[ch_q*H_W +: H_W] <= qx_q[H_W-1:0];
                        cy_q[ch_q*V_W +: V_W] <= quo_q[V_W-1:0];
                        valid_q[ch_q]         <= 1'b1;
                    end
                    if (ch_q == CH_W'(NCH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ch_q    <= ch_q + CH_W'(1);
                        state_q <= CHECK;
                    end
                end
                DONE: begin
                    ch_q    <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cx      = cx_q;
    assign cy      = cy_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Scoreboard bench for centroid_tracker: a per-frame arithmetic model predicts
// results, done/overrun timing and busy windows; a negedge monitor checks them.
`timescale 1ns/1ps

module tb_centroid_tracker;

    localparam int HA   = 1024;
    localparam int VA   = 768;
    localparam int MINC = 16;
    localparam int SW   = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [1:0]  match;
    logic [21:0] cx;
    logic [19:0] cy;
    logic [1:0]  valid;
    logic        busy;
    logic        done;
    logic        overrun;

    centroid_tracker dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .match(match),
        .cx(cx), .cy(cy), .valid(valid), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [21:0] cx;
        logic [19:0] cy;
        logic [1:0]  valid;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   total = 0;
    int   bad   = 0;

    longint      sx[2], sy[2], cnt[2];
    logic [10:0] m_cx[2];
    logic [9:0]  m_cy[2];
    logic [1:0]  m_valid;
    int          busy_from = 0;
    int          busy_to   = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++) begin
            sx[c] = 0; sy[c] = 0; cnt[c] = 0; m_cx[c] = '0; m_cy[c] = '0;
        end
        m_valid   = '0;
        busy_to   = -1;
        busy_from = 0;
        exp_q.delete();
        ovr_q.delete();
    endtask

    // Frame-level reference: sums/counts per channel, snapshot at frame end unless busy.
    task automatic model_pixel(input int h, input int v, input logic [1:0] m, input int k);
        exp_t e;
        int   lat;
        if (h == 0 && v == 0) begin
            for (int c = 0; c < 2; c++) begin sx[c] = 0; sy[c] = 0; cnt[c] = 0; end
        end else if (h < HA && v < VA) begin
            for (int c = 0; c < 2; c++) if (m[c]) begin sx[c] += h; sy[c] += v; cnt[c] += 1; end
        end
        if (h == HA - 1 && v == VA - 1) begin
            if (k >= busy_from && k <= busy_to) begin
                ovr_q.push_back(k + 1);
            end else begin
                lat = 1;
                for (int c = 0; c < 2; c++) begin
                    if (cnt[c] >= MINC) begin
                        m_cx[c] = 11'(sx[c] / cnt[c]);
                        m_cy[c] = 10'(sy[c] / cnt[c]);
                        m_valid[c] = 1'b1;
                        lat += 2 * SW + 2;
                    end else begin
                        m_valid[c] = 1'b0;
                        lat += 2;
                    end
                end
                e.cyc = k + lat;
                e.cx  = {m_cx[1], m_cx[0]};
                e.cy  = {m_cy[1], m_cy[0]};
                e.valid = m_valid;
                exp_q.push_back(e);
                busy_from = k + 1;
                busy_to   = k + lat;
            end
        end
    endtask

    task automatic pix(input int h, input int v, input logic [1:0] m);
        hcount = 11'(h);
        vcount = 10'(v);
        match  = m;
        @(posedge clk);
        #1;
        model_pixel(h, v, m, cyc);
    endtask

    task automatic idle();
        pix(1100, 800, 2'($urandom_range(0, 3)));
    endtask

    task automatic wait_free();
        for (int i = 0; i < 1000 && cyc <= busy_to + 1; i++) idle();
    endtask

    task automatic frame_end_when_free(input logic [1:0] m);
        for (int i = 0; i < 1000 && cyc + 1 <= busy_to; i++) idle();
        pix(HA - 1, VA - 1, m);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rst_busy", busy, 0);
        chk("rst_cx", cx, 0);
        chk("rst_cy", cy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
        if (done || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
            chk("done_pending", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                chk("done_at", done, 1);
                chk("done_cycle", cyc, me.cyc);
                if (done) begin
                    chk("cx", cx, me.cx);
                    chk("cy", cy, me.cy);
                    chk("valid", valid, me.valid);
                end
            end
        end
        if (overrun || (ovr_q.size() > 0 && ovr_q[0] <= cyc)) begin
            chk("overrun_pending", (ovr_q.size() > 0) ? 1 : 0, 1);
            if (ovr_q.size() > 0) begin
                chk("overrun_at", overrun, 1);
                chk("overrun_cycle", cyc, ovr_q.pop_front());
            end
        end
    end

    initial begin
        reset  = 1'b1;
        hcount = 11'd1100;
        vcount = 10'd800;
        match  = 2'b00;
        model_clear();
        pulse_reset(3);

        // 16 hits on one pixel: exact centroid, second channel skipped
        pix(0, 0, 2'b11);
        repeat (16) pix(100, 50, 2'b01);
        pix(HA - 1, VA - 1, 2'b00);
        wait_free();

        // 10x10 block on channel 1, centroid floors 204.5
        pix(0, 0, 2'b00);
        for (int v = 300; v < 310; v++)
            for (int h = 200; h < 210; h++) pix(h, v, 2'b10);
        pix(HA - 1, VA - 1, 2'b00);
        wait_free();

        // valid frame at 300, then a 5-hit frame must invalidate and hold cx0
        pix(0, 0, 2'b00);
        repeat (16) pix(300, 400, 2'b01);
        pix(HA - 1, VA - 1, 2'b00);
        wait_free();
        pix(0, 0, 2'b00);
        repeat (5) pix(300, 400, 2'b01);
        pix(HA - 1, VA - 1, 2'b00);
        wait_free();

        // same pixels on both channels; frame-end pixel itself also matches
        pix(0, 0, 2'b00);
        repeat (20) pix($urandom_range(1, HA - 1), $urandom_range(0, VA - 1), 2'b11);
        pix(HA - 1, VA - 1, 2'b11);
        wait_free();

        // shortened second frame ends while busy: dropped with one overrun pulse
        pix(0, 0, 2'b00);
        repeat (20) pix($urandom_range(1, HA - 1), $urandom_range(1, VA - 1), 2'b01);
        pix(HA - 1, VA - 1, 2'b00);
        pix(0, 0, 2'b00);
        repeat (6) pix($urandom_range(1, HA - 1), $urandom_range(1, VA - 1), 2'b11);
        pix(HA - 1, VA - 1, 2'b00);
        wait_free();

        // reset in the middle of channel 0's y division
        pix(0, 0, 2'b00);
        repeat (18) pix($urandom_range(1, HA - 1), $urandom_range(1, VA - 1), 2'b11);
        pix(HA - 1, VA - 1, 2'b00);
        for (int i = 0; i < 200 && cyc < busy_from + 40; i++) idle();
        pulse_reset(1);
        repeat (80) idle();

        // random frames, next frame accumulating while the previous one divides
        for (int f = 0; f < 8; f++) begin
            pix(0, 0, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 70))
                pix($urandom_range(0, 1100), $urandom_range(0, 800), 2'($urandom_range(0, 3)));
            frame_end_when_free(2'($urandom_range(0, 3)));
        end
        wait_free();
        repeat (5) idle();

        chk("done_queue_empty", exp_q.size(), 0);
        chk("overrun_queue_empty", ovr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
